// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// master: upstream pipeline (drives ID/EX fields, observes results and stall).
// slave : the execute stage itself.
interface ex_stage_if #(
    parameter int B = 32,
    parameter int W = 5
);
    // ID/EX pipeline register outputs
    logic [W-1:0] pc_next_in;
    logic [B-1:0] r_data1_in;
    logic [B-1:0] r_data2_in;
    logic [B-1:0] sign_ext_in;
    logic [W-1:0] inst_20_16_in;
    logic [W-1:0] inst_15_11_in;
    logic         wb_RegWrite_in;
    logic         wb_MemtoReg_in;
    logic         m_Branch_in;
    logic         m_MemRead_in;
    logic         m_MemWrite_in;
    logic         ex_RegDst_in;
    logic         ex_ALUOp_in;
    logic         ex_ALUSrc_in;

    // Hazard feedback and EX/MEM pipeline register outputs
    logic         stall_out;
    logic [W-1:0] branch_target_out;
    logic [B-1:0] alu_result_out;
    logic         zero_out;
    logic [B-1:0] w_data_out;
    logic [W-1:0] w_reg_out;
    logic         wb_RegWrite_out;
    logic         wb_MemtoReg_out;
    logic         m_Branch_out;
    logic         m_MemRead_out;
    logic         m_MemWrite_out;

    modport master (
        output pc_next_in, r_data1_in, r_data2_in, sign_ext_in,
               inst_20_16_in, inst_15_11_in,
               wb_RegWrite_in, wb_MemtoReg_in, m_Branch_in, m_MemRead_in,
               m_MemWrite_in, ex_RegDst_in, ex_ALUOp_in, ex_ALUSrc_in,
        input  stall_out, branch_target_out, alu_result_out, zero_out,
               w_data_out, w_reg_out,
               wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out,
               m_MemRead_out, m_MemWrite_out
    );

    modport slave (
        input  pc_next_in, r_data1_in, r_data2_in, sign_ext_in,
               inst_20_16_in, inst_15_11_in,
               wb_RegWrite_in, wb_MemtoReg_in, m_Branch_in, m_MemRead_in,
               m_MemWrite_in, ex_RegDst_in, ex_ALUOp_in, ex_ALUSrc_in,
        output stall_out, branch_target_out, alu_result_out, zero_out,
               w_data_out, w_reg_out,
               wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out,
               m_MemRead_out, m_MemWrite_out
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch-target adder, iterative shift-add
// multiplier (one partial product per cycle) and the EX/MEM register.
module ex_stage #(
    parameter int B = 32,
    parameter int W = 5
) (
    input logic       clk,
    input logic       reset,
    ex_stage_if.slave ex
);
    localparam int CW = $clog2(B);
    localparam logic [CW-1:0] LAST = CW'(B - 1);

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [5:0] F_MUL = 6'h18;

    typedef enum logic {IDLE, MUL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [B-1:0]  mcand_q, mcand_d;
    logic [B-1:0]  mplier_q, mplier_d;
    logic [B-1:0]  acc_q, acc_d;

    // EX/MEM register; ctl = {RegWrite, MemtoReg, Branch, MemRead, MemWrite}
    logic [W-1:0]  bt_q, bt_d;
    logic [B-1:0]  alu_q, alu_d;
    logic          zero_q, zero_d;
    logic [B-1:0]  wdata_q, wdata_d;
    logic [W-1:0]  wreg_q, wreg_d;
    logic [4:0]    ctl_q, ctl_d;

    logic [B-1:0]  op_b, alu_res, acc_step, load_val;
    logic [5:0]    funct;
    logic          is_mul, stall, load, bubble;

    // ALU operand select and single-cycle operation decode
    always_comb begin
        op_b    = ex.ex_ALUSrc_in ? ex.sign_ext_in : ex.r_data2_in;
        funct   = ex.sign_ext_in[5:0];
        is_mul  = ex.ex_ALUOp_in && !ex.m_Branch_in && (funct == F_MUL);
        alu_res = '0;
        if (ex.m_Branch_in) begin
            alu_res = ex.r_data1_in - op_b;
        end else if (!ex.ex_ALUOp_in) begin
            alu_res = ex.r_data1_in + op_b;
        end else begin
            case (funct)
                F_ADD:   alu_res = ex.r_data1_in + op_b;
                F_SUB:   alu_res = ex.r_data1_in - op_b;
                F_AND:   alu_res = ex.r_data1_in & op_b;
                F_OR:    alu_res = ex.r_data1_in | op_b;
                F_SLT:   alu_res = {{(B-1){1'b0}},
                                    ($signed(ex.r_data1_in) < $signed(op_b))};
                default: alu_res = '0;
            endcase
        end
    end

    // Multiply FSM: next state, iteration datapath, stall and EX/MEM load/bubble
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        stall    = 1'b0;
        load     = 1'b0;
        bubble   = 1'b0;
        load_val = alu_res;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    stall    = 1'b1;
                    bubble   = 1'b1;
                    mcand_d  = ex.r_data1_in;
                    mplier_d = op_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = MUL;
                end else begin
                    load = 1'b1;
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q != LAST) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end else begin
                    // last partial product is folded in combinationally
                    load     = 1'b1;
                    load_val = acc_step;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // EX/MEM next values: load new results, or bubble (clear controls, hold data)
    always_comb begin
        bt_d    = bt_q;
        alu_d   = alu_q;
        zero_d  = zero_q;
        wdata_d = wdata_q;
        wreg_d  = wreg_q;
        ctl_d   = ctl_q;
        if (load) begin
            bt_d    = ex.pc_next_in + ex.sign_ext_in[W-1:0];
            alu_d   = load_val;
            zero_d  = (load_val == '0);
            wdata_d = ex.r_data2_in;
            wreg_d  = ex.ex_RegDst_in ? ex.inst_15_11_in : ex.inst_20_16_in;
            ctl_d   = {ex.wb_RegWrite_in, ex.wb_MemtoReg_in, ex.m_Branch_in,
                       ex.m_MemRead_in, ex.m_MemWrite_in};
        end else if (bubble) begin
            ctl_d = '0;
        end
    end

    // State, multiplier and EX/MEM registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            bt_q     <= '0;
            alu_q    <= '0;
            zero_q   <= 1'b0;
            wdata_q  <= '0;
            wreg_q   <= '0;
            ctl_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            bt_q     <= bt_d;
            alu_q    <= alu_d;
            zero_q   <= zero_d;
            wdata_q  <= wdata_d;
            wreg_q   <= wreg_d;
            ctl_q    <= ctl_d;
        end
    end

    assign ex.stall_out         = stall;
    assign ex.branch_target_out = bt_q;
    assign ex.alu_result_out    = alu_q;
    assign ex.zero_out          = zero_q;
    assign ex.w_data_out        = wdata_q;
    assign ex.w_reg_out         = wreg_q;
    assign ex.wb_RegWrite_out   = ctl_q[4];
    assign ex.wb_MemtoReg_out   = ctl_q[3];
    assign ex.m_Branch_out      = ctl_q[2];
    assign ex.m_MemRead_out     = ctl_q[1];
    assign ex.m_MemWrite_out    = ctl_q[0];
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized
// single-cycle ops against an arithmetic reference, and multiply sequences.
module tb_ex_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage_if #(.B(32), .W(5)) bus ();
    ex_stage #(.B(32), .W(5)) dut (.clk(clk), .reset(reset), .ex(bus));

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] r2;
        logic [31:0] se;
        logic [4:0]  pc;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        alusrc;
        logic        aluop;
        logic        regdst;
        logic [4:0]  ctl;      // {RegWrite, MemtoReg, Branch, MemRead, MemWrite}
        logic [31:0] exp_res;
        logic        exp_zero;
        logic [4:0]  exp_wreg;
        logic [4:0]  exp_bt;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] r2, input logic [31:0] se,
                         input logic [4:0] pc, input logic [4:0] rt, input logic [4:0] rd,
                         input logic alusrc, input logic aluop, input logic regdst,
                         input logic [4:0] ctl);
        bus.r_data1_in     = a;
        bus.r_data2_in     = r2;
        bus.sign_ext_in    = se;
        bus.pc_next_in     = pc;
        bus.inst_20_16_in  = rt;
        bus.inst_15_11_in  = rd;
        bus.ex_ALUSrc_in   = alusrc;
        bus.ex_ALUOp_in    = aluop;
        bus.ex_RegDst_in   = regdst;
        bus.wb_RegWrite_in = ctl[4];
        bus.wb_MemtoReg_in = ctl[3];
        bus.m_Branch_in    = ctl[2];
        bus.m_MemRead_in   = ctl[1];
        bus.m_MemWrite_in  = ctl[0];
    endtask

    function automatic logic [4:0] out_ctl();
        return {bus.wb_RegWrite_out, bus.wb_MemtoReg_out, bus.m_Branch_out,
                bus.m_MemRead_out, bus.m_MemWrite_out};
    endfunction

    // Reference ALU from the instruction-set rules, plain arithmetic
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] funct, input logic aluop,
                                            input logic branch);
        longint signed sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (branch)       return a - b;
        if (!aluop)       return a + b;
        if (funct == 6'h20) return a + b;
        if (funct == 6'h22) return a - b;
        if (funct == 6'h24) return a & b;
        if (funct == 6'h25) return a | b;
        if (funct == 6'h2A) return (sa < sb) ? 32'd1 : 32'd0;
        if (funct == 6'h18) return a * b;
        return 32'd0;
    endfunction

    // Runs one MUL already presented at the inputs; expects 32 stall cycles,
    // bubbles throughout, then the product with RegWrite and rd.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input string tag);
        int  stalls = 0;
        bit  bad_bubble = 0;
        drive(a, b, 32'h18, 5'd0, 5'd7, rd, 1'b0, 1'b1, 1'b1, 5'b10000);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!bus.stall_out) break;
            stalls++;
            @(posedge clk); #1;
            if (out_ctl() !== 5'b0) bad_bubble = 1;
        end
        chk({tag, " stall_cycles"}, stalls, 32);
        chk({tag, " bubble_ctl"}, {31'd0, bad_bubble}, 32'd0);
        @(posedge clk); #1;
        chk({tag, " product"}, bus.alu_result_out, ref_alu(a, b, 6'h18, 1'b1, 1'b0));
        chk({tag, " regwrite"}, {31'd0, bus.wb_RegWrite_out}, 32'd1);
        chk({tag, " w_reg"}, {27'd0, bus.w_reg_out}, {27'd0, rd});
    endtask

    initial begin
        //            a             r2            se            pc     rt     rd     src  op   dst  ctl       res           z    wreg   bt
        tbl[0] = '{32'd5,        32'd7,        32'h20,       5'd0,  5'd9,  5'd3,  1'b0,1'b1,1'b1,5'b10000, 32'd12,       1'b0,5'd3, 5'd0};
        tbl[1] = '{32'h1234,     32'h1234,     32'd3,        5'd4,  5'd2,  5'd6,  1'b0,1'b0,1'b0,5'b00100, 32'd0,        1'b1,5'd2, 5'd7};
        tbl[2] = '{32'hFFFFFFFF, 32'd1,        32'h2A,       5'd1,  5'd1,  5'd4,  1'b0,1'b1,1'b1,5'b10000, 32'd1,        1'b0,5'd4, 5'd11};
        tbl[3] = '{32'd0,        32'd1,        32'h22,       5'd0,  5'd5,  5'd8,  1'b0,1'b1,1'b1,5'b10000, 32'hFFFFFFFF, 1'b0,5'd8, 5'd2};
        tbl[4] = '{32'd3,        32'd4,        32'h3F,       5'd0,  5'd5,  5'd9,  1'b0,1'b1,1'b1,5'b10000, 32'd0,        1'b1,5'd9, 5'd31};
        tbl[5] = '{32'd10,       32'h55,       32'hFFFFFFFE, 5'd3,  5'd12, 5'd1,  1'b1,1'b0,1'b0,5'b11010, 32'd8,        1'b0,5'd12,5'd1};
        tbl[6] = '{32'hF0F0,     32'hFF00,     32'h24,       5'd31, 5'd0,  5'd10, 1'b0,1'b1,1'b1,5'b10000, 32'hF000,     1'b0,5'd10,5'd3};
        tbl[7] = '{32'hF0F0,     32'h0F0F,     32'h25,       5'd0,  5'd0,  5'd11, 1'b0,1'b1,1'b1,5'b00001, 32'hFFFF,     1'b0,5'd11,5'd5};
        tbl[8] = '{32'd5,        32'hFFFFFFFD, 32'h2A,       5'd0,  5'd0,  5'd13, 1'b0,1'b1,1'b1,5'b10000, 32'd0,        1'b1,5'd13,5'd10};

        // Reset state
        reset = 1'b1;
        drive('0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 5'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset alu_result", bus.alu_result_out, 32'd0);
        chk("reset ctl", {27'd0, out_ctl()}, 32'd0);
        chk("reset stall", {31'd0, bus.stall_out}, 32'd0);
        reset = 1'b0;

        // Directed single-cycle vectors
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].a, tbl[i].r2, tbl[i].se, tbl[i].pc, tbl[i].rt, tbl[i].rd,
                  tbl[i].alusrc, tbl[i].aluop, tbl[i].regdst, tbl[i].ctl);
            #1;
            chk($sformatf("vec%0d stall", i), {31'd0, bus.stall_out}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d alu_result", i), bus.alu_result_out, tbl[i].exp_res);
            chk($sformatf("vec%0d zero", i), {31'd0, bus.zero_out}, {31'd0, tbl[i].exp_zero});
            chk($sformatf("vec%0d w_reg", i), {27'd0, bus.w_reg_out}, {27'd0, tbl[i].exp_wreg});
            chk($sformatf("vec%0d branch_target", i), {27'd0, bus.branch_target_out}, {27'd0, tbl[i].exp_bt});
            chk($sformatf("vec%0d ctl", i), {27'd0, out_ctl()}, {27'd0, tbl[i].ctl});
            chk($sformatf("vec%0d w_data", i), bus.w_data_out, tbl[i].r2);
        end

        // Randomized single-cycle operations against the reference
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, r2, se, b, exp;
            logic [4:0]  pc, rt, rd, ctl;
            logic        src, op, dst;
            logic [5:0]  functs [6];
            functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
            a   = $urandom;
            r2  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            se  = $urandom;
            se[5:0] = functs[$urandom_range(0, 5)];
            if (se[5:0] == 6'h00) se[5:0] = 6'($urandom_range(0, 63));
            if (se[5:0] == 6'h18) se[5:0] = 6'h19;
            pc  = 5'($urandom);
            rt  = 5'($urandom);
            rd  = 5'($urandom);
            ctl = 5'($urandom);
            src = 1'($urandom);
            op  = 1'($urandom);
            dst = 1'($urandom);
            b   = src ? se : r2;
            exp = ref_alu(a, b, se[5:0], op, ctl[2]);
            drive(a, r2, se, pc, rt, rd, src, op, dst, ctl);
            #1;
            chk($sformatf("rnd%0d stall", i), {31'd0, bus.stall_out}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("rnd%0d alu_result", i), bus.alu_result_out, exp);
            chk($sformatf("rnd%0d zero", i), {31'd0, bus.zero_out}, {31'd0, exp == 32'd0});
            chk($sformatf("rnd%0d w_reg", i), {27'd0, bus.w_reg_out}, {27'd0, dst ? rd : rt});
            chk($sformatf("rnd%0d branch_target", i), {27'd0, bus.branch_target_out},
                {27'd0, 5'((int'(pc) + int'(se[4:0])) % 32)});
            chk($sformatf("rnd%0d ctl", i), {27'd0, out_ctl()}, {27'd0, ctl});
        end

        // Multiply sequences, including back-to-back restarts
        run_mul(32'h00010003, 32'h00020005, 5'd14, "mul_a");
        chk("mul_a value", bus.alu_result_out, 32'h000B000F);
        run_mul(32'd3, 32'd4, 5'd15, "mul_b2b1");
        chk("mul_b2b1 value", bus.alu_result_out, 32'd12);
        run_mul(32'hFFFFFFFF, 32'd2, 5'd16, "mul_b2b2");
        chk("mul_b2b2 value", bus.alu_result_out, 32'hFFFFFFFE);
        for (int i = 0; i < 3; i++) begin
            run_mul($urandom, $urandom, 5'($urandom), $sformatf("mul_rnd%0d", i));
        end

        // Unknown funct after the multiplies
        drive(32'd9, 32'd9, 32'h3F, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 5'b10000);
        @(posedge clk); #1;
        chk("unknown funct", bus.alu_result_out, 32'd0);

        // Reset in the middle of a multiply, then ADD 1+1
        drive(32'd7, 32'd9, 32'h18, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 5'b10000);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        drive(32'd1, 32'd1, 32'h20, 5'd0, 5'd3, 5'd4, 1'b0, 1'b1, 1'b1, 5'b10000);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort alu_result", bus.alu_result_out, 32'd0);
        chk("abort ctl", {27'd0, out_ctl()}, 32'd0);
        chk("abort w_reg", {27'd0, bus.w_reg_out}, 32'd0);
        chk("abort stall", {31'd0, bus.stall_out}, 32'd0);
        @(posedge clk); #1;
        chk("post-abort add", bus.alu_result_out, 32'd2);
        chk("post-abort regwrite", {31'd0, bus.wb_RegWrite_out}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX pipeline register outputs and contains the ALU, the branch-target adder and an iterative 32-cycle multiplier.
- Registers its results into an internal EX/MEM pipeline register.
- Drives a stall to upstream stages while a multiply is in progress.

Parameters:
- B, 32, data width
- W, 5, width of pc_next and of the register-index fields

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- pc_next_in  in  W  PC+1 from ID/EX
- r_data1_in  in  B  operand A
- r_data2_in  in  B  operand B / store data
- sign_ext_in  in  B  immediate; bits [5:0] are funct
- inst_20_16_in  in  W  rt
- inst_15_11_in  in  W  rd
- wb_RegWrite_in, wb_MemtoReg_in, m_Branch_in, m_MemRead_in, m_MemWrite_in  in  1 each  passthrough controls
- ex_RegDst_in, ex_ALUOp_in, ex_ALUSrc_in  in  1 each  EX controls
- stall_out  in→out  1  output, high = upstream must hold PC, IF/ID and ID/EX
- branch_target_out  out  W  registered pc_next + sign_ext[W-1:0]
- alu_result_out  out  B  registered
- zero_out  out  1  registered, alu_result == 0
- w_data_out  out  B  registered r_data2
- w_reg_out  out  W  registered destination register
- wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out, m_MemWrite_out  out  1 each  registered controls

Behaviour:
- One clock (clk); reset is synchronous and active-high. On reset all outputs are 0, the FSM goes to IDLE and the counter is cleared. Reset during a multiply aborts it: no result is written and stall_out is 0 in the next cycle.
- Operand B is sign_ext_in if ex_ALUSrc_in = 1, else r_data2_in.
- ALU operation select:
  - m_Branch_in = 1: SUB.
  - Else ex_ALUOp_in = 0: ADD.
  - Else decode funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x18 MUL. Any other funct gives result 0.
- Arithmetic wraps mod 2^B with no overflow trap. SLT is a signed compare giving 1 or 0. MUL keeps the low B bits of the product.
- w_reg = inst_15_11_in if ex_RegDst_in = 1, else inst_20_16_in. branch_target is a W-bit add of pc_next_in and sign_ext_in[W-1:0], truncated.
- FSM IDLE:
  - Non-MUL instruction: EX/MEM loads the ALU result and all passthrough fields at the clock edge. Latency is 1 cycle. stall_out = 0.
  - MUL instruction: stall_out = 1 combinationally in the same cycle. Capture multiplicand = A and multiplier = B, clear accumulator, count = 0, go to MUL. EX/MEM loads a bubble: all control outputs 0; data fields hold their previous values.
- FSM MUL:
  - Each cycle: if multiplier[0] = 1, add multiplicand into the accumulator. Then shift multiplicand left 1, shift multiplier right 1, count++.
  - stall_out = 1 while count < 31. EX/MEM loads a bubble each of these cycles.
  - At count == 31: final step is combinational, stall_out = 0, EX/MEM loads the accumulator result with the controls and w_reg of the held ID/EX inputs, then go to IDLE.
- MUL timing: MUL present in EX at cycle t gives stall_out high for cycles t..t+31 (32 cycles) and the result visible at outputs in cycle t+33.
- Upstream holds the ID/EX inputs stable while stall_out = 1. The block relies only on its captured operands plus the held control and w_reg fields.
- A MUL immediately following a MUL is re-detected in IDLE and restarts normally; there is no back-to-back shortcut.
- MUL with m_Branch_in = 1 cannot occur, since branch forces SUB.

Test Plan:
- ALUOp=1, funct 0x20, A=5, B=7, RegDst=1, rd=3 → next cycle alu_result=12, w_reg=3, zero=0, stall never asserted.
- Branch=1, A=B=0x1234, pc_next=4, sign_ext=3 → alu_result=0, zero=1, branch_target=7, m_Branch_out=1.
- SLT with A=0xFFFFFFFF, B=1 → alu_result=1. SUB with A=0, B=1 → 0xFFFFFFFF (wrap).
- MUL with A=0x00010003, B=0x00020005 → stall_out high exactly 32 cycles, bubbles with RegWrite_out=0 during the stall, then alu_result=0x000B000F with RegWrite_out=1.
- Reset asserted in cycle 10 of a MUL → outputs all 0 next cycle, stall_out=0; following ADD 1+1 → 2 with 1-cycle latency.
- Back-to-back MULs (3×4, then 0xFFFFFFFF×2) → results 12 and 0xFFFFFFFE, each preceded by 32 stall cycles; unknown funct 0x3F → result 0.
